// File: rtl/mask_stream_source.sv
// Threshold-window pixel source: emits (x, y) beats for in-window pixels and a
// per-frame tabulate pulse carrying the hit count for a downstream centroid unit.
module mask_stream_source #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720,
    parameter int DATA_W   = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic [DATA_W-1:0] pixel_in,
    input  logic              pixel_valid_in,
    input  logic              enable_in,
    input  logic [DATA_W-1:0] lower_bound_in,
    input  logic [DATA_W-1:0] upper_bound_in,
    output logic [10:0]       x_out,
    output logic [9:0]        y_out,
    output logic              valid_out,
    output logic              tabulate_out,
    output logic [19:0]       pixel_count_out,
    output logic              frame_error_out
);

    localparam logic [10:0] H_END = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  V_END = 10'(V_ACTIVE - 1);

    typedef enum logic [1:0] {WAIT_SOF, ACTIVE, FLUSH, TABULATE} state_t;

    state_t            state, next_state;
    logic              flush_cnt;
    logic [DATA_W-1:0] lo_q, hi_q;
    logic [19:0]       hit_cnt;
    logic              s1_hit;
    logic [10:0]       s1_x;
    logic [9:0]        s1_y;

    logic              accepted, at_sof, at_last;
    logic              start, process, truncate, hit;
    logic [DATA_W-1:0] lo_eff, hi_eff;

    assign accepted = pixel_valid_in && (hcount_in <= H_END) && (vcount_in <= V_END);
    assign at_sof   = (hcount_in == '0) && (vcount_in == '0);
    assign at_last  = (hcount_in == H_END) && (vcount_in == V_END);

    always_comb begin
        next_state = state;
        start      = 1'b0;
        process    = 1'b0;
        truncate   = 1'b0;
        case (state)
            WAIT_SOF: begin
                if (accepted && at_sof && enable_in) begin
                    start      = 1'b1;
                    process    = 1'b1;
                    next_state = at_last ? FLUSH : ACTIVE;
                end
            end
            ACTIVE: begin
                if (accepted) begin
                    if (at_sof) begin
                        // Restart mid-frame: abandon the frame, optionally reopen at once
                        truncate = 1'b1;
                        if (enable_in) begin
                            start      = 1'b1;
                            process    = 1'b1;
                            next_state = ACTIVE;
                        end else begin
                            next_state = WAIT_SOF;
                        end
                    end else begin
                        process = 1'b1;
                        if (at_last) next_state = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt) next_state = TABULATE;
            end
            TABULATE: next_state = WAIT_SOF;
            default:  next_state = WAIT_SOF;
        endcase
    end

    // The frame-opening beat is judged against the bounds being latched with it
    assign lo_eff = start ? lower_bound_in : lo_q;
    assign hi_eff = start ? upper_bound_in : hi_q;
    assign hit    = process && (pixel_in >= lo_eff) && (pixel_in <= hi_eff);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= WAIT_SOF;
            flush_cnt <= 1'b0;
            lo_q      <= '0;
            hi_q      <= '0;
            hit_cnt   <= '0;
        end else begin
            state     <= next_state;
            flush_cnt <= (state == FLUSH) ? ~flush_cnt : 1'b0;
            if (start) begin
                lo_q    <= lower_bound_in;
                hi_q    <= upper_bound_in;
                hit_cnt <= {19'd0, hit};
            end else if (hit) begin
                hit_cnt <= hit_cnt + 20'd1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s1_hit          <= 1'b0;
            s1_x            <= '0;
            s1_y            <= '0;
            valid_out       <= 1'b0;
            x_out           <= '0;
            y_out           <= '0;
            tabulate_out    <= 1'b0;
            pixel_count_out <= '0;
            frame_error_out <= 1'b0;
        end else begin
            s1_hit <= hit;
            if (hit) begin
                s1_x <= hcount_in;
                s1_y <= vcount_in;
            end
            valid_out <= s1_hit;
            if (s1_hit) begin
                x_out <= s1_x;
                y_out <= s1_y;
            end
            tabulate_out <= (state == FLUSH) && flush_cnt;
            if ((state == FLUSH) && flush_cnt) pixel_count_out <= hit_cnt;
            frame_error_out <= truncate;
        end
    end

endmodule
